// File: rtl/alu_issue_stage.sv
// Decode/operand stage feeding an external combinational ALU and writing back its result.
// Optional ZERO_REG_EN: R0 reads as zero on every read path and ignores writes.
module alu_issue_stage #(
    parameter int NUM_REGS = 16,
    parameter int DATA_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    input  logic [15:0]       instr,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [7:0]        alu_opcode,
    input  logic [DATA_W-1:0] alu_c,
    input  logic [4:0]        alu_flags,
    output logic [4:0]        psr_flags,
    output logic              wb_valid,
    output logic [3:0]        wb_addr,
    output logic [DATA_W-1:0] wb_data,
    input  logic [3:0]        dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    typedef enum logic {S_IDLE, S_EXEC} state_t;

    state_t                           r_state, w_next;
    logic [NUM_REGS-1:0][DATA_W-1:0]  r_regs;
    logic [DATA_W-1:0]                r_a, r_b, r_wb_data;
    logic [7:0]                       r_op;
    logic [3:0]                       r_dest, r_wb_addr;
    logic [4:0]                       r_psr;
    logic                             r_wb_valid;

    logic [DATA_W-1:0] w_rd_a, w_rd_src, w_rd_dbg, w_imm, w_b;
    logic              w_accept, w_wb, w_we, w_is_cmp;

    function automatic logic [DATA_W-1:0] rd(input logic [3:0] addr,
                                             input logic [NUM_REGS-1:0][DATA_W-1:0] regs);
`ifdef ZERO_REG_EN
        if (addr == 4'd0) return '0;
`endif
        return regs[addr];
    endfunction

    assign w_rd_a   = rd(instr[11:8], r_regs);
    assign w_rd_src = rd(instr[3:0], r_regs);
    assign w_rd_dbg = rd(dbg_addr, r_regs);

    // ADDUI zero-extends its immediate; every other immediate op sign-extends.
    assign w_imm = (instr[15:12] == 4'h6) ? {{(DATA_W-8){1'b0}}, instr[7:0]}
                                          : {{(DATA_W-8){instr[7]}}, instr[7:0]};
    assign w_b   = (instr[15:12] == 4'h0) ? w_rd_src : w_imm;

    assign w_is_cmp = (r_op == 8'h0B) || (r_op[7:4] == 4'hB);
    assign w_wb     = (r_state == S_EXEC) && (r_op != 8'h00);
`ifdef ZERO_REG_EN
    assign w_we     = w_wb && !w_is_cmp && (r_dest != 4'd0);
`else
    assign w_we     = w_wb && !w_is_cmp;
`endif
    assign w_accept = instr_ready && instr_valid;

    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) w_next = S_EXEC;
            end
            S_EXEC:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_regs     <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= '0;
            r_dest     <= '0;
            r_psr      <= '0;
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else begin
            r_state    <= w_next;
            r_wb_valid <= w_wb;
            if (w_accept) begin
                r_a    <= w_rd_a;
                r_b    <= w_b;
                r_op   <= {instr[15:12], instr[7:4]};
                r_dest <= instr[11:8];
            end
            if (w_wb) begin
                r_psr     <= alu_flags;
                r_wb_addr <= r_dest;
                r_wb_data <= alu_c;
            end
            if (w_we) r_regs[r_dest] <= alu_c;
        end
    end

    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_opcode = r_op;
    assign psr_flags  = r_psr;
    assign wb_valid   = r_wb_valid;
    assign wb_addr    = r_wb_addr;
    assign wb_data    = r_wb_data;
    assign dbg_data   = w_rd_dbg;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
Decode/operand stage that sits directly upstream of the ALU and also consumes its result.
- Accepts one 16-bit instruction and reads the 16x16 register file.
- Forms A, B and the 8-bit ALU opcode, holds them stable for one execute cycle.
- Captures C and Flags into the destination register and the processor status register (PSR).
- Serial two-state machine: one instruction per two cycles, so no hazard logic is needed.

Parameters:
NUM_REGS, 16, register count; register address width is 4 bits.
DATA_W, 16, datapath width; must equal the ALU width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction offered
instr  in  16  [15:12] op, [11:8] Rdest, [7:4] opext/immHi, [3:0] Rsrc/immLo
instr_ready  out  1  stage can accept an instruction
alu_a  out  16  operand A to ALU
alu_b  out  16  operand B to ALU
alu_opcode  out  8  opcode to ALU
alu_c  in  16  ALU result, combinational
alu_flags  in  5  ALU flags {Z,C,O,N,L}
psr_flags  out  5  status register
wb_valid  out  1  one-cycle pulse on register/PSR update
wb_addr  out  4  register written (valid with wb_valid)
wb_data  out  16  value written (valid with wb_valid)
dbg_addr  in  4  debug read address
dbg_data  out  16  combinational read of R[dbg_addr]

Behaviour:
Reset (asserted asynchronously, any state):
- All registers R0..R15, psr_flags and the operand registers go to 0.
- State goes to IDLE. An in-flight instruction is dropped with no writeback.
- Outputs: instr_ready=1 and wb_valid=0; all others 0.

States:
- IDLE: instr_ready=1.
  - On an edge with instr_valid=1, latch the operands below and the dest address, then go to EXEC.
  - With instr_valid=0, stay in IDLE.
- EXEC: instr_ready=0. alu_a, alu_b and alu_opcode are held from registers and stay stable for the whole cycle.
  - At the end of the cycle, perform writeback, pulse wb_valid for the following cycle, and return to IDLE.

Operand formation:
- alu_opcode = {instr[15:12], instr[7:4]}.
- alu_a = R[instr[11:8]].
- Register form (instr[15:12]==0): alu_b = R[instr[3:0]].
- Immediate form (instr[15:12]!=0): imm8 = instr[7:0].
  - alu_b is zero-extended when instr[15:12]==4'h6 (ADDUI).
  - Otherwise alu_b is sign-extended from bit 7.

Writeback rules at the end of EXEC:
- alu_opcode==8'h00 (WAIT): no register write, PSR unchanged, wb_valid stays 0.
- Compare (alu_opcode==8'h0B, or instr[15:12]==4'hB): psr_flags<=alu_flags, no register write. wb_valid pulses with wb_addr=dest and wb_data=alu_c.
- All other opcodes (including ones the ALU does not recognise): R[dest]<=alu_c and psr_flags<=alu_flags. wb_valid pulses with wb_addr/wb_data.

Timing and boundaries:
- Latency: instruction accepted at edge N → ALU operands valid during cycle N..N+1 → R/PSR updated at edge N+1 → earliest next accept at edge N+2.
- Rdest==Rsrc is legal; the old value is read.
- dbg_data reflects a write starting the cycle after the writeback edge.
- instr_valid held high in EXEC is ignored; the instruction is not consumed until instr_ready=1.
- Arithmetic is entirely in the ALU; this stage never modifies alu_c or alu_flags.

Optional Feature:
ZERO_REG_EN
- Defined: R0 reads as 0 on every read path, including dbg_data. Writes to R0 are discarded, but the PSR still updates and wb_valid still pulses with wb_addr=0.
- Undefined: R0 is an ordinary register.

Test Plan:
1. Reset then ADD: preload R1=0x0005, R2=0x0003; issue instr=0x0152 → R1=0x0008, psr_flags=0, wb_valid pulse with wb_addr=1 and wb_data=0x0008, two cycles after accept.
2. Immediate sign-extend: R3=0x0010; issue ADDI 0x53F0 (imm=0xF0) → alu_b=0xFFF0, R3=0x0000, psr_flags[4]=1.
3. ADDUI zero-extend: R4=0xFF20; issue 0x64E0 → alu_b=0x00E0 and R4=0x0000.
4. CMP 0x05B6 with R5=2, R6=7 → R5 unchanged at 2, psr_flags[1:0]=2'b11; then WAIT 0x0000 → psr_flags unchanged, no wb_valid.
5. Back-to-back: instr_valid held high with two ADDs → instr_ready low during EXEC, second accepted exactly two cycles after the first, both writebacks correct.
6. Reset mid-op: assert rst_n=0 during EXEC → no write, all R and PSR read 0, instr_ready=1 after release. With ZERO_REG_EN, an ADDI to R0 leaves dbg_data(0)=0.
